// File: rtl/mux_sel_arbiter_if.sv
// Bus bundle for mux_sel_arbiter: request/lock/data inputs and
// grant/select/result outputs. Master drives requests, slave is the arbiter.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [3:0] lock;
  logic [1:0] d0;
  logic [1:0] d1;
  logic [1:0] d2;
  logic [1:0] d3;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic [1:0] result;
  logic       valid;
  logic       busy;

  modport master (
    output req, lock, d0, d1, d2, d3,
    input  gnt, s0, s1, result, valid, busy
  );

  modport slave (
    input  req, lock, d0, d1, d2, d3,
    output gnt, s0, s1, result, valid, busy
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin 4-way arbiter steering a shared 4:1 2-bit mux.
// Each tenure lasts HOLD_CYCLES edges or until the holder drops req.
// Optional feature: define MUX_ARB_LOCK_EN to let the granted requester
// extend its tenure by holding lock together with req.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  mux_sel_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] result_q, result_d;
  logic       valid_q;

  logic [1:0] winner;
  logic [1:0] mux_data;
  logic       lock_hold;
  logic       tenure_end;

  // Search last+1, last+2, last+3, last; the most recent holder comes last,
  // so it only wins again when nobody else is asking.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef MUX_ARB_LOCK_EN
  // Extension only applies to the current holder while it still requests.
  assign lock_hold = bus.lock[sel_q] & bus.req[sel_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign lock_hold   = 1'b0;
`endif

  assign winner = rr_pick(bus.req, last_q);

  // Shared data mux driven by the current select.
  always_comb begin
    case (sel_q)
      2'd0:    mux_data = bus.d0;
      2'd1:    mux_data = bus.d1;
      2'd2:    mux_data = bus.d2;
      default: mux_data = bus.d3;
    endcase
  end

  // Next-state, grant, counter and result computation.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    tenure_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
          cnt_d   = CNT_LOAD;
        end
      end
      GRANT: begin
        result_d   = mux_data;
        tenure_end = (cnt_q == '0) || !bus.req[sel_q];
        if (!tenure_end) begin
          cnt_d = cnt_q - 4'd1;
        end else if (lock_hold) begin
          cnt_d = CNT_LOAD;
        end else if (|bus.req) begin
          gnt_d  = 4'b0001 << winner;
          sel_d  = winner;
          last_d = winner;
          cnt_d  = CNT_LOAD;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; last starts at 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      last_q   <= 2'd3;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= (state_q == GRANT);
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.s0     = sel_q[0];
  assign bus.s1     = sel_q[1];
  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = (state_q == GRANT);

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, grant length in cycles per tenure; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per requester i (bit i); held high until served.
REQ-005 lock  input  4  extend-tenure request per requester; used only when MUX_ARB_LOCK_EN is defined.
REQ-006 d0, d1, d2, d3  input  2 each  requester data words feeding the shared 4:1 2-bit mux.
REQ-007 gnt  output  4  one-hot grant, registered; all-zero when no tenure is active.
REQ-008 s0, s1  output  1 each  mux select; {s1,s0} = granted index, registered.
REQ-009 result  output  2  registered mux output.
REQ-010 valid  output  1  result qualifies the granted requester's data.
REQ-011 busy  output  1  high while in GRANT state.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-013 In IDLE with req != 0 at an edge, the block SHALL enter GRANT at that edge: gnt one-hot, {s1,s0} = index, counter = HOLD_CYCLES-1 (1-cycle req-to-gnt latency).
REQ-014 Winner selection SHALL be round-robin: search order last+1, last+2, last+3, last (mod 4), where last = most recently granted index.
REQ-015 In GRANT, each edge SHALL decrement counter while counter > 0 and req[granted] = 1.
REQ-016 Tenure SHALL end at an edge where counter = 0, or req[granted] = 0 (early release); the lock extension in REQ-023 overrides this.
REQ-017 At tenure end with req pending (granted bit excluded unless it is the only one), the next winner SHALL be granted at the same edge with no idle bubble.
REQ-018 At tenure end with no req pending, the block SHALL return to IDLE and clear gnt.
REQ-019 {s1,s0} SHALL hold the last granted index in IDLE.
REQ-020 result SHALL load the selected dN at every edge in GRANT and hold its value in IDLE.
REQ-021 valid SHALL be busy delayed by one cycle, so valid high means result came from the granted requester.
REQ-022 A requester whose req drops before being granted SHALL be skipped with no side effects.

Configuration
REQ-023 With MUX_ARB_LOCK_EN defined, at tenure end with lock[g] = 1 and req[g] = 1 for the granted g, the grant SHALL be retained and counter reloaded to HOLD_CYCLES-1; lock on non-granted bits SHALL be ignored.
REQ-024 Without MUX_ARB_LOCK_EN, the lock port SHALL remain present but be ignored, and no lock logic SHALL be synthesized.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, gnt = 0000, s0 = s1 = 0, result = 00, valid = 0, busy = 0, counter = 0, last = 3.
REQ-026 Reset asserted mid-tenure SHALL abort the grant; after release, arbitration SHALL restart with requester 0 highest priority.
REQ-027 The first active edge after rst_n deasserts SHALL be able to grant.

Verification
REQ-028 Reset, then req = 0001, d0 = 10, HOLD_CYCLES = 1 -> next edge gnt = 0001, {s1,s0} = 00; one edge later result = 10, valid = 1.
REQ-029 req = 1111 held, HOLD_CYCLES = 1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive edges, busy continuously 1.
REQ-030 HOLD_CYCLES = 3, req = 0100 then 0110 -> gnt = 0100 for 3 cycles, then 0010 with no gap.
REQ-031 HOLD_CYCLES = 4, req[2] dropped after 1 granted cycle -> early release; gnt = 0000 and busy = 0 at the next edge if no other req is pending.
REQ-032 With MUX_ARB_LOCK_EN defined, req = 0011, lock = 0001, HOLD_CYCLES = 1 -> gnt stays 0001 until lock[0] falls, then 0010; without the macro -> 0001, 0010 alternating.
REQ-033 rst_n pulsed low during a tenure with gnt = 1000 -> gnt = 0000, valid = 0 asynchronously; after release with req = 1001 -> gnt = 0001 first.
